eu_arbiter: RTL



---
 rtl/eu_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/eu_arbiter.sv
// Two-port arbiter that shares one combinational Extension_Unit between decode (port 0)
// and the branch-target predecoder (port 1); returns registered, ID-tagged immediates.
module eu_arbiter #(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [31:0] req0_instr,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_instr,
    output logic        req1_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_imm,
    output logic        resp_err,
    output logic [2:0]  eu_ceu,
    output logic [24:0] eu_dint,
    input  logic [31:0] eu_dout
);

    typedef enum logic [1:0] {StIdle, StExt, StResp} state_e;

    localparam logic [2:0] CeuNone = 3'd7;

    state_e      state_q, state_d;
    logic        last_grant_q;
    logic        id_q;
    logic [31:0] instr_q;
    logic        gnt_valid;
    logic        gnt_id;
    logic        accept;
    logic [2:0]  cls;
    logic        cls_err;

    function automatic logic [2:0] classify(input logic [6:0] op);
        case (op)
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: return 3'd0;
            7'b0100011:                                     return 3'd1;
            7'b1100011:                                     return 3'd2;
            7'b0110111, 7'b0010111:                         return 3'd3;
            7'b1101111:                                     return 3'd4;
            default:                                        return CeuNone;
        endcase
    endfunction

    assign cls     = classify(instr_q[6:0]);
    assign cls_err = (cls == CeuNone);

    // Round-robin favours whoever did not win last; a lone requester always wins.
    always_comb begin
        gnt_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            gnt_id = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
        end else begin
            gnt_id = ~req0_valid;
        end
        accept     = (state_q == StIdle) && gnt_valid && !rst;
        req0_ready = accept && !gnt_id;
        req1_ready = accept && gnt_id;
        eu_ceu     = (state_q == StExt) ? cls : CeuNone;
        eu_dint    = instr_q[31:7];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = StExt;
            StExt:   state_d = StResp;
            StResp:  if (resp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            instr_q      <= '0;
            resp_valid   <= 1'b0;
            resp_id      <= 1'b0;
            resp_imm     <= '0;
            resp_err     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                instr_q      <= gnt_id ? req1_instr : req0_instr;
                id_q         <= gnt_id;
                last_grant_q <= gnt_id;
            end
            if (state_q == StExt) begin
                resp_valid <= 1'b1;
                resp_id    <= id_q;
                resp_err   <= cls_err;
                resp_imm   <= cls_err ? 32'd0 : eu_dout;
            end else if (state_q == StResp && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

endmodule
